// File: rtl/neuron_controller_if.sv
// Handshake/bus bundle between the neuron controller, its datapath and the result consumer.
// master = controller side, slave = datapath/consumer side.
interface neuron_controller_if;
  logic        start;
  logic [15:0] index;
  logic        ld;
  logic        dp_clr;
  logic [15:0] result_in;
  logic [15:0] result_out;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, result_in, result_ready,
    output index, ld, dp_clr, result_out, result_valid, busy, done
  );

  modport slave (
    output start, result_in, result_ready,
    input  index, ld, dp_clr, result_out, result_valid, busy, done
  );
endinterface

// File: rtl/neuron_controller.sv
// Sequencer for one neuron evaluation: CLEAR, n ACCUM beats, SETTLE, then HOLD until accepted.
// Optional macro NEURON_CTRL_STALL_EN adds a stall input that freezes the ACCUM beat.
module neuron_controller #(
  parameter int unsigned n = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef NEURON_CTRL_STALL_EN
  input  logic               stall,
`endif
  neuron_controller_if.master bus
);

  localparam logic [15:0] LAST = 16'(n - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t      state, nxt;
  logic [15:0] cnt;
  logic [15:0] res_q;
  logic        stall_i;
  logic        ld_c, clr_c, done_c;
  logic [15:0] idx_c;

`ifdef NEURON_CTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Beat counter saturates at LAST; it is rewound in CLEAR so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (state == CLEAR)
      cnt <= '0;
    else if (state == ACCUM && !stall_i && cnt != LAST)
      cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      res_q <= '0;
    else if (state == SETTLE)
      res_q <= bus.result_in;
  end

  always_comb begin
    nxt    = state;
    ld_c   = 1'b0;
    clr_c  = 1'b0;
    done_c = 1'b0;
    idx_c  = '0;
    unique case (state)
      IDLE: if (bus.start) nxt = CLEAR;
      CLEAR: begin
        clr_c = 1'b1;
        nxt   = ACCUM;
      end
      ACCUM: begin
        idx_c = cnt;
        ld_c  = !stall_i;
        if (!stall_i && cnt == LAST) nxt = SETTLE;
      end
      SETTLE: nxt = HOLD;
      HOLD: if (bus.result_ready) begin
        done_c = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.index        = idx_c;
  assign bus.ld           = ld_c;
  assign bus.dp_clr       = clr_c;
  assign bus.result_out   = res_q;
  assign bus.result_valid = (state == HOLD);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_c;

endmodule

// File: tb/tb_neuron_controller.sv
// Bench for neuron_controller: directed scenarios plus randomized traffic against a timeline model.
module tb_neuron_controller;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_controller_if bus ();
  neuron_controller_if bus1 ();

`ifdef NEURON_CTRL_STALL_EN
  logic stall = 1'b0;
  logic stall1 = 1'b0;
`endif

  neuron_controller #(.n(N)) dut (
    .clk(clk), .rst(rst),
`ifdef NEURON_CTRL_STALL_EN
    .stall(stall),
`endif
    .bus(bus)
  );

  neuron_controller #(.n(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef NEURON_CTRL_STALL_EN
    .stall(stall1),
`endif
    .bus(bus1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0 = 0;
  int vrise = -1;
  int ld_cnt = 0, clr_cnt = 0, done_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an evaluation is a clear cycle, N load beats (stalled cycles insert gaps),
  // one settle cycle, then hold until the consumer takes the result.
  bit          m_act = 0, m_clr = 0, m_post = 0;
  int          m_k = 0;
  logic [15:0] m_res = '0;

  always @(negedge clk) begin : compare
    bit   clr, acc, st, hold, stl;
    logic [20:0] exp_o, act_o;
    stl = 1'b0;
`ifdef NEURON_CTRL_STALL_EN
    stl = stall;
`endif
    if (!rst) begin
      m_act = 0; m_res = '0;
    end
    clr  = m_act && m_clr;
    acc  = m_act && !m_clr && m_k < N;
    st   = m_act && !m_clr && m_k == N && !m_post;
    hold = m_act && !m_clr && m_k == N && m_post;
    exp_o = {m_act, acc && !stl, clr, hold, hold && bus.result_ready,
             acc ? 16'(m_k) : 16'd0};
    act_o = {bus.busy, bus.ld, bus.dp_clr, bus.result_valid, bus.done, bus.index};
    chk("outs", 32'(act_o), 32'(exp_o));
    chk("result_out", 32'(bus.result_out), 32'(m_res));
    if (bus.ld) ld_cnt++;
    if (bus.dp_clr) clr_cnt++;
    if (bus.done) done_cnt++;
    if (bus.result_valid && !prev_valid) vrise = cyc;
    prev_valid = bus.result_valid;
    if (rst) begin
      if (!m_act) begin
        if (bus.start) begin
          m_act = 1; m_clr = 1; m_k = 0; m_post = 0;
        end
      end else if (clr) m_clr = 0;
      else if (acc) begin
        if (!stl) m_k++;
      end else if (st) begin
        m_res = bus.result_in; m_post = 1;
      end else if (hold && bus.result_ready) m_act = 0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1; e0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic clr_counts();
    ld_cnt = 0; clr_cnt = 0; done_cnt = 0; vrise = -1;
  endtask

  task automatic wait_idle(input string nm);
    int b;
    b = 0;
    while (bus.busy && b < 200) begin @(negedge clk); b++; end
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int b;
    b = 0;
    while (!bus.result_valid && b < 200) begin @(negedge clk); b++; end
    chk(nm, 32'(bus.result_valid), 32'd1);
  endtask

  initial begin
    int d0, b, ld1, v1, dn1;
    bus.start = 0; bus.result_ready = 0; bus.result_in = '0;
    bus1.start = 0; bus1.result_ready = 0; bus1.result_in = '0;
    #1;
    chk("reset_outs", 32'({bus.busy, bus.ld, bus.dp_clr, bus.result_valid, bus.done, bus.index}), 32'd0);
    chk("reset_result", 32'(bus.result_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic run: one clear, 16 loads, valid 19 edges after start is driven, one done
    bus.result_ready = 1'b1; bus.result_in = 16'h1234;
    clr_counts();
    pulse_start();
    wait_idle("basic_idle");
    @(negedge clk);
    chk("basic_latency", 32'(vrise - e0), 32'd19);
    chk("basic_ld_cnt", 32'(ld_cnt), 32'd16);
    chk("basic_clr_cnt", 32'(clr_cnt), 32'd1);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_result", 32'(bus.result_out), 32'h1234);

    // Back-pressure: result holds while the consumer is not ready
    bus.result_ready = 1'b0; bus.result_in = 16'h00A5;
    clr_counts();
    pulse_start();
    wait_valid("bp_valid");
    @(posedge clk); #1 bus.result_in = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_result", 32'(bus.result_out), 32'h00A5);
      chk("bp_hold_valid", 32'(bus.result_valid), 32'd1);
    end
    chk("bp_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1 bus.result_ready = 1'b1;
    @(posedge clk); #1 bus.result_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_once", 32'(done_cnt), 32'd1);
    chk("bp_retained", 32'(bus.result_out), 32'h00A5);

    // Start pulses while busy are ignored
    clr_counts();
    pulse_start();
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1; @(posedge clk); #1 bus.start = 1'b0;
    wait_valid("ign_valid");
    @(posedge clk); #1 bus.start = 1'b1; @(posedge clk); #1 bus.start = 1'b0;
    bus.result_ready = 1'b1;
    wait_idle("ign_idle");
    repeat (3) @(negedge clk);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_clr_cnt", 32'(clr_cnt), 32'd1);

    // Reset in the middle of accumulation
    clr_counts();
    pulse_start();
    b = 0;
    while (bus.index != 16'd7 && b < 50) begin @(posedge clk); #1; b++; end
    chk("rst_reach_idx7", 32'(bus.index), 32'd7);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({bus.busy, bus.ld, bus.dp_clr, bus.result_valid, bus.done, bus.index}), 32'd0);
    chk("rst_mid_result", 32'(bus.result_out), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    clr_counts();
    pulse_start();
    wait_idle("rst_next_idle");
    chk("rst_next_clr", 32'(clr_cnt), 32'd1);
    chk("rst_next_ld", 32'(ld_cnt), 32'd16);

    // Single-beat configuration
    bus1.result_ready = 1'b1; bus1.result_in = 16'h0042;
    ld1 = 0; v1 = -1; dn1 = 0;
    @(posedge clk); #1 bus1.start = 1'b1; d0 = cyc;
    @(posedge clk); #1 bus1.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus1.ld) begin
        ld1++;
        chk("n1_index", 32'(bus1.index), 32'd0);
      end
      if (bus1.done) dn1++;
      if (bus1.result_valid && v1 < 0) v1 = cyc;
    end
    chk("n1_ld_cnt", 32'(ld1), 32'd1);
    chk("n1_latency", 32'(v1 - d0), 32'd4);
    chk("n1_done", 32'(dn1), 32'd1);
    chk("n1_result", 32'(bus1.result_out), 32'h0042);

`ifdef NEURON_CTRL_STALL_EN
    // Three stall cycles at index 4 push valid out by three edges
    clr_counts();
    bus.result_ready = 1'b1;
    pulse_start();
    b = 0;
    while (bus.index != 16'd4 && b < 50) begin @(posedge clk); #1; b++; end
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_idx", 32'(bus.index), 32'd4);
      chk("stall_ld", 32'(bus.ld), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    wait_idle("stall_idle");
    chk("stall_latency", 32'(vrise - e0), 32'd22);
    chk("stall_ld_cnt", 32'(ld_cnt), 32'd16);
`endif

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.start        = ($urandom_range(0, 3) == 0);
      bus.result_ready = ($urandom_range(0, 2) == 0);
      bus.result_in    = 16'($urandom);
`ifdef NEURON_CTRL_STALL_EN
      stall = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end
endmodule
